trig_fire_sequencer: RTL and testbench

- Converts incoming trigger edges into timed output pulses on the distribution board.
- Fires the latched channel pattern for a programmable width, then holds off for a programmable dead time.
- Counts accepted and rejected triggers.
- Sits between the trigger input synchronisers and the output drivers. Its configuration inputs (firingticks, deadticks, enable_outputs) come from the serial command processor.

---
 rtl/trig_fire_sequencer_if.sv | 20 ++
 rtl/trig_fire_sequencer.sv | 91 +++++++++
 tb/tb_trig_fire_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/trig_fire_sequencer_if.sv
// trig_fire_sequencer_if: trigger/config inputs and fire/status outputs of the fire sequencer
interface trig_fire_sequencer_if #(parameter int NCH = 8);
  logic [NCH-1:0] trig_in;
  logic           enable_outputs;
  logic [7:0]     firingticks;
  logic [7:0]     deadticks;
  logic           clear_counts;
  logic [NCH-1:0] fire_out;
  logic           busy;
  logic [31:0]    fire_count;
  logic [15:0]    missed_count;
  modport master (
    output trig_in, enable_outputs, firingticks, deadticks, clear_counts,
    input  fire_out, busy, fire_count, missed_count
  );
  modport slave (
    input  trig_in, enable_outputs, firingticks, deadticks, clear_counts,
    output fire_out, busy, fire_count, missed_count
  );
endinterface

// File: rtl/trig_fire_sequencer.sv
// trig_fire_sequencer: turns trigger edges into timed fire pulses followed by a dead time,
// counting accepted and rejected triggers
module trig_fire_sequencer #(
  parameter int NCH = 8
) (
  input logic                 clk,
  input logic                 reset,
  trig_fire_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  logic [1:0]     state_q, state_d;
  logic [NCH-1:0] trig_q, fire_q, fire_d, rise;
  logic           busy_q, busy_d;
  logic [31:0]    fcnt_q, fcnt_d;
  logic [15:0]    mcnt_q, mcnt_d;
  logic [7:0]     wcnt_q, wcnt_d, dcnt_q, dcnt_d, dlat_q, dlat_d;
  logic           evt, accept, missed;
  assign rise   = bus.trig_in & ~trig_q;
  assign evt    = |rise;
  assign accept = state_q == IDLE && evt && !bus.enable_outputs;
  assign missed = state_q != IDLE && evt;
  // Counters step only on events; a clear in the same cycle always wins
  assign fcnt_d = bus.clear_counts ? '0 : fcnt_q + {31'd0, accept};
  assign mcnt_d = bus.clear_counts ? '0 : mcnt_q + {15'd0, missed && mcnt_q != 16'hFFFF};
  always_comb begin
    state_d = state_q;
    fire_d  = fire_q;
    busy_d  = busy_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    dlat_d  = dlat_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = FIRE;
        fire_d  = rise;
        busy_d  = 1'b1;
        wcnt_d  = bus.firingticks == 8'd0 ? 8'd1 : bus.firingticks;
        dlat_d  = bus.deadticks;
      end
      // A disable cuts the pulse short but still serves the whole dead time
      FIRE: if (bus.enable_outputs || wcnt_q == 8'd1) begin
        fire_d  = '0;
        state_d = dlat_q == 8'd0 ? IDLE : DEAD;
        busy_d  = dlat_q != 8'd0;
        dcnt_d  = dlat_q;
      end else begin
        wcnt_d = wcnt_q - 8'd1;
      end
      DEAD: if (dcnt_q <= 8'd1) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        dcnt_d = dcnt_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        fire_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      trig_q  <= '1;
      fire_q  <= '0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
      mcnt_q  <= '0;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      dlat_q  <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= bus.trig_in;
      fire_q  <= fire_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      dlat_q  <= dlat_d;
    end
  end
  assign bus.fire_out     = fire_q;
  assign bus.busy         = busy_q;
  assign bus.fire_count   = fcnt_q;
  assign bus.missed_count = mcnt_q;
endmodule

// File: tb/tb_trig_fire_sequencer.sv
// tb_trig_fire_sequencer: directed scenarios with a pulse scoreboard; expected pulses are
// queued when a trigger is driven and checked by a monitor as fire_out pulses appear
module tb_trig_fire_sequencer;
  typedef struct {
    logic [7:0] pat;
    int         len;
  } pulse_t;
  logic   clk = 1'b0;
  logic   reset;
  pulse_t exp_q[$];
  pulse_t cur;
  int     n_cmp = 0;
  int     n_err = 0;
  int     n;
  int     len;
  bit     active = 0;
  bit     mon_en = 1;
  trig_fire_sequencer_if #(.NCH(8)) bus();
  trig_fire_sequencer #(.NCH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.clear_counts = 1'b1;
    cyc(1);
    bus.clear_counts = 1'b0;
  endtask
  task automatic busy_len(output int k);
    k = 0;
    while (bus.busy && k < 1000) begin
      k++;
      cyc(1);
    end
  endtask
  task automatic trig(input logic [7:0] pat, input int exp_len);
    bus.trig_in = pat;
    exp_q.push_back('{pat: pat, len: exp_len});
  endtask
  // Pulse monitor: samples 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!mon_en) begin
        active = 0;
      end else if (!active && bus.fire_out != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(bus.fire_out), 32'h0);
        end else begin
          cur = exp_q.pop_front();
          check("pulse_pat", 32'(bus.fire_out), 32'(cur.pat));
          active = 1;
          len = 1;
        end
      end else if (active && bus.fire_out == 8'h00) begin
        check("pulse_len", 32'(len), 32'(cur.len));
        active = 0;
      end else if (active) begin
        if (bus.fire_out != cur.pat) check("pulse_pat_hold", 32'(bus.fire_out), 32'(cur.pat));
        len++;
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.trig_in = 8'hFF;
    bus.enable_outputs = 1'b0;
    bus.firingticks = 8'd9;
    bus.deadticks = 8'd10;
    bus.clear_counts = 1'b0;
    cyc(2);
    check("rst_fire", 32'(bus.fire_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_fcnt", bus.fire_count, 32'h0);
    check("rst_mcnt", 32'(bus.missed_count), 32'h0);
    reset = 1'b0;
    cyc(3);
    check("rel_high_nofire", bus.fire_count, 32'h0);
    check("rel_high_busy", 32'(bus.busy), 32'h0);
    bus.trig_in = 8'h00;
    cyc(2);
    // 1: basic pulse F=9 D=10
    trig(8'h05, 9);
    cyc(1);
    bus.trig_in = 8'h00;
    check("t1_fire", 32'(bus.fire_out), 32'h05);
    check("t1_fcnt", bus.fire_count, 32'h1);
    busy_len(n);
    check("t1_busy_len", 32'(n), 32'd19);
    check("t1_mcnt", 32'(bus.missed_count), 32'h0);
    // 2: zero width and dead time
    bus.firingticks = 8'd0;
    bus.deadticks = 8'd0;
    clr();
    check("t2_clr", bus.fire_count, 32'h0);
    for (int i = 0; i < 2; i++) begin
      trig(8'h01, 1);
      cyc(1);
      bus.trig_in = 8'h00;
      check("t2_busy_on", 32'(bus.busy), 32'h1);
      cyc(1);
      check("t2_busy_off", 32'(bus.busy), 32'h0);
    end
    check("t2_fcnt", bus.fire_count, 32'h2);
    // 3: rises during FIRE and DEAD are missed, held level does not re-fire
    bus.firingticks = 8'd4;
    bus.deadticks = 8'd4;
    clr();
    trig(8'h02, 4);
    cyc(2);
    bus.trig_in = 8'h06;
    cyc(4);
    bus.trig_in = 8'h0E;
    cyc(10);
    check("t3_mcnt", 32'(bus.missed_count), 32'h2);
    check("t3_fcnt", bus.fire_count, 32'h1);
    check("t3_busy", 32'(bus.busy), 32'h0);
    bus.trig_in = 8'h00;
    cyc(2);
    // 4: disable mid-FIRE, then a trigger while disabled
    bus.firingticks = 8'd20;
    bus.deadticks = 8'd6;
    clr();
    trig(8'h01, 5);
    cyc(1);
    bus.trig_in = 8'h00;
    cyc(4);
    bus.enable_outputs = 1'b1;
    cyc(1);
    check("t4_fire_off", 32'(bus.fire_out), 32'h0);
    busy_len(n);
    check("t4_dead_len", 32'(n), 32'd6);
    bus.trig_in = 8'h01;
    cyc(1);
    check("t4_dis_fire", 32'(bus.fire_out), 32'h0);
    check("t4_dis_busy", 32'(bus.busy), 32'h0);
    bus.trig_in = 8'h00;
    cyc(2);
    check("t4_fcnt", bus.fire_count, 32'h1);
    check("t4_mcnt", 32'(bus.missed_count), 32'h0);
    bus.enable_outputs = 1'b0;
    // 5: config change mid-pulse applies to the next trigger
    bus.firingticks = 8'd9;
    bus.deadticks = 8'd2;
    clr();
    trig(8'h01, 9);
    cyc(1);
    bus.trig_in = 8'h00;
    bus.firingticks = 8'd3;
    busy_len(n);
    check("t5_busy1", 32'(n), 32'd11);
    trig(8'h01, 3);
    cyc(1);
    bus.trig_in = 8'h00;
    busy_len(n);
    check("t5_busy2", 32'(n), 32'd5);
    check("t5_fcnt", bus.fire_count, 32'h2);
    // 6: missed_count saturation, clear vs accept, async reset in FIRE
    bus.firingticks = 8'd255;
    bus.deadticks = 8'd255;
    clr();
    mon_en = 0;
    for (int i = 0; i < 66000; i++) begin
      bus.trig_in = (i % 2 == 1) ? 8'hAA : 8'h55;
      cyc(1);
    end
    check("t6_sat", 32'(bus.missed_count), 32'hFFFF);
    bus.trig_in = 8'h00;
    busy_len(n);
    check("t6_idle", 32'(bus.busy), 32'h0);
    cyc(2);
    mon_en = 1;
    bus.firingticks = 8'd2;
    bus.deadticks = 8'd0;
    bus.clear_counts = 1'b1;
    trig(8'h01, 2);
    cyc(1);
    bus.clear_counts = 1'b0;
    bus.trig_in = 8'h00;
    check("t6_clr_fcnt", bus.fire_count, 32'h0);
    check("t6_clr_mcnt", 32'(bus.missed_count), 32'h0);
    cyc(4);
    bus.firingticks = 8'd10;
    bus.deadticks = 8'd5;
    trig(8'h02, 3);
    cyc(3);
    check("t6_pre_rst_fire", 32'(bus.fire_out), 32'h02);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rst_fire", 32'(bus.fire_out), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'h0);
    check("t6_rst_fcnt", bus.fire_count, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(4);
    check("t6_held_nofire", bus.fire_count, 32'h0);
    check("t6_held_busy", 32'(bus.busy), 32'h0);
    bus.trig_in = 8'h00;
    cyc(2);
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
